// File: rtl/regression_predictor_pkg.sv
// Shared types and constants for the linear-model predictor and its saturating stage.
package regression_predictor_pkg;

  localparam int unsigned DW   = 20;
  localparam int unsigned FRAC = 10;
  localparam int unsigned N    = 150;
  localparam int unsigned CW   = 9;
  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned SW   = DW + FRAC + 1;

  typedef logic [DW-1:0] data_t;
  typedef logic [PW-1:0] prod_t;
  typedef logic [CW-1:0] cnt_t;

  // Stage-1 payload: the product travels with the intercept it was paired with.
  typedef struct packed {
    logic  valid;
    prod_t prod;
    data_t b0;
  } stage1_t;

  localparam data_t DATA_MAX = '1;

  // Batch counter step that holds at N instead of wrapping.
  function automatic cnt_t cnt_inc_sat(input cnt_t c);
    cnt_t r;
    r = c;
    if (c < CW'(N)) begin
      r = c + CW'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/pred_stage2_sat.sv
// Combinational b0 + (prod >> FRAC) with clamp to the DW-bit unsigned range.
module pred_stage2_sat
  import regression_predictor_pkg::*;
(
  input  prod_t prod_i,
  input  data_t b0_i,
  output data_t y_c,
  output logic  ovf_c
);

  logic [SW-1:0] sum_c;

  // Shift truncates toward zero; the sum is wide enough to never wrap.
  always_comb begin
    sum_c = SW'(b0_i) + SW'(prod_i >> FRAC);
    ovf_c = (sum_c > SW'(DATA_MAX));
    y_c   = ovf_c ? DATA_MAX : sum_c[DW-1:0];
  end

endmodule

// File: rtl/regression_predictor.sv
// Two-stage valid/ready evaluator of y = b0 + b1*x with coefficient latching and batch counting.
module regression_predictor
  import regression_predictor_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          coef_ld,
  input  logic [DW-1:0] b0_in,
  input  logic [DW-1:0] b1_in,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_x,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_y,
  output logic          m_ovf,
  output logic [CW-1:0] count,
  output logic          done
);

  data_t   b0r_q, b0r_d;
  data_t   b1r_q, b1r_d;
  stage1_t s1_q, s1_d;
  logic    v2_q, v2_d;
  data_t   m_y_q, m_y_d;
  logic    m_ovf_q, m_ovf_d;
  cnt_t    count_q, count_d;
  logic    done_q, done_d;

  logic    adv1, adv2;
  data_t   y_sat;
  logic    ovf_sat;

  pred_stage2_sat u_sat (
    .prod_i (s1_q.prod),
    .b0_i   (s1_q.b0),
    .y_c    (y_sat),
    .ovf_c  (ovf_sat)
  );

  // Pipeline advance, coefficient latch and batch counter next-state.
  always_comb begin
    b0r_d   = b0r_q;
    b1r_d   = b1r_q;
    s1_d    = s1_q;
    v2_d    = v2_q;
    m_y_d   = m_y_q;
    m_ovf_d = m_ovf_q;
    count_d = count_q;
    done_d  = done_q;

    adv2    = !v2_q || m_ready;
    adv1    = !s1_q.valid || adv2;
    s_ready = adv1 && !done_q;

    // A sample accepted alongside coef_ld still sees the old registers.
    if (coef_ld) begin
      b0r_d = b0_in;
      b1r_d = b1_in;
    end

    if (adv1) begin
      s1_d.valid = s_valid && s_ready;
      s1_d.prod  = prod_t'(s_x) * prod_t'(b1r_q);
      s1_d.b0    = b0r_q;
    end

    if (adv2) begin
      v2_d    = s1_q.valid;
      m_y_d   = y_sat;
      m_ovf_d = ovf_sat;
    end

    if (coef_ld) begin
      count_d = '0;
    end else if (v2_q && m_ready) begin
      count_d = cnt_inc_sat(count_q);
    end
    done_d = (count_d == CW'(N));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      b0r_q   <= '0;
      b1r_q   <= '0;
      s1_q    <= '0;
      v2_q    <= 1'b0;
      m_y_q   <= '0;
      m_ovf_q <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      b0r_q   <= b0r_d;
      b1r_q   <= b1r_d;
      s1_q    <= s1_d;
      v2_q    <= v2_d;
      m_y_q   <= m_y_d;
      m_ovf_q <= m_ovf_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign m_valid = v2_q;
  assign m_y     = m_y_q;
  assign m_ovf   = m_ovf_q;
  assign count   = count_q;
  assign done    = done_q;

endmodule

// File: tb/tb_regression_predictor.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, randomized traffic vs. a queue model.
module tb_regression_predictor;
  import regression_predictor_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          coef_ld;
  logic [DW-1:0] b0_in, b1_in;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_x;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_y;
  logic          m_ovf;
  logic [CW-1:0] count;
  logic          done;

  regression_predictor dut (
    .clk(clk), .rst(rst), .coef_ld(coef_ld), .b0_in(b0_in), .b1_in(b1_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x),
    .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_ovf(m_ovf),
    .count(count), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [19:0] y;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [19:0] b0;
    logic [19:0] b1;
    logic [19:0] x;
    logic [19:0] y;
    logic        ovf;
  } vec_t;

  exp_t        exp_q[$];
  logic [19:0] got_q[$];
  longint unsigned mb0 = 0, mb1 = 0;
  int          mcnt = 0;
  bit          armed = 0;
  bit          prev_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: y = b0 + floor(x*b1 / 1024), clamped to 20 bits.
  function automatic exp_t model(input longint unsigned b0, input longint unsigned b1,
                                 input longint unsigned x);
    exp_t e;
    longint unsigned s;
    s = b0 + ((x * b1) / 1024);
    if (s > 64'hFFFFF) begin
      e.y   = 20'hFFFFF;
      e.ovf = 1'b1;
    end else begin
      e.y   = 20'(s);
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Monitor: inputs are stable from negedge to the next posedge, so this sees the upcoming transfers.
  always @(negedge clk) begin
    if (armed) begin
      chk("count", 64'(count), 64'(mcnt));
      chk("done", 64'(done), 64'(mcnt == N));
      if (mcnt == N) chk("s_ready_while_done", 64'(s_ready), 64'd0);
      if (prev_stall) chk("m_valid_hold", 64'(m_valid), 64'd1);
      if (exp_q.size() == 0) begin
        chk("m_valid_idle", 64'(m_valid), 64'd0);
      end else if (m_valid) begin
        chk("m_y", 64'(m_y), 64'(exp_q[0].y));
        chk("m_ovf", 64'(m_ovf), 64'(exp_q[0].ovf));
      end
    end
    if (!rst) begin
      exp_q.delete();
      mb0 = 0;
      mb1 = 0;
      mcnt = 0;
      prev_stall = 0;
      armed = 1;
    end else if (armed) begin
      prev_stall = m_valid && !m_ready;
      if (m_valid && m_ready && exp_q.size() > 0) begin
        got_q.push_back(m_y);
        void'(exp_q.pop_front());
        if (mcnt < N) mcnt++;
      end
      if (s_valid && s_ready) exp_q.push_back(model(mb0, mb1, 64'(s_x)));
      if (coef_ld) begin
        mb0 = 64'(b0_in);
        mb1 = 64'(b1_in);
        mcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coef(input logic [19:0] b0, input logic [19:0] b1);
    coef_ld = 1'b1;
    b0_in   = b0;
    b1_in   = b1;
    tick();
    coef_ld = 1'b0;
  endtask

  function automatic logic [19:0] rand_data();
    logic [19:0] r;
    case ($urandom_range(0, 2))
      0:       r = 20'($urandom_range(0, 2047));
      1:       r = 20'($urandom_range(0, 16383));
      default: r = 20'($urandom);
    endcase
    return r;
  endfunction

  vec_t vecs[10];

  initial begin
    int g, lat, acc;
    logic [19:0] x, y0;
    bit a;

    vecs[0] = '{20'd100,     20'd2048,    20'd50,      20'd200,     1'b0};
    vecs[1] = '{20'd0,       20'd512,     20'd7,       20'd3,       1'b0};
    vecs[2] = '{20'd0,       20'd512,     20'd1,       20'd0,       1'b0};
    vecs[3] = '{20'hFFFF0,   20'd1024,    20'h20,      20'hFFFFF,   1'b1};
    vecs[4] = '{20'hFFFF0,   20'd1024,    20'd0,       20'hFFFF0,   1'b0};
    vecs[5] = '{20'd0,       20'd1,       20'd1023,    20'd0,       1'b0};
    vecs[6] = '{20'd0,       20'd1,       20'd1024,    20'd1,       1'b0};
    vecs[7] = '{20'hFFFFE,   20'd1024,    20'd1,       20'hFFFFF,   1'b0};
    vecs[8] = '{20'hFFFFF,   20'd1024,    20'd1,       20'hFFFFF,   1'b1};
    vecs[9] = '{20'd0,       20'hFFFFF,   20'hFFFFF,   20'hFFFFF,   1'b1};

    rst = 1'b0; coef_ld = 1'b0; b0_in = '0; b1_in = '0;
    s_valid = 1'b0; s_x = '0; m_ready = 1'b1;
    repeat (3) tick();
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_y", 64'(m_y), 64'd0);
    chk("rst_m_ovf", 64'(m_ovf), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    rst = 1'b1;
    tick();

    // Vector table: one sample per coefficient pair, latency and value checked directly.
    for (int i = 0; i < 10; i++) begin
      load_coef(vecs[i].b0, vecs[i].b1);
      m_ready = 1'b1;
      s_x     = vecs[i].x;
      s_valid = 1'b1;
      g = 0;
      while (!s_ready && g < 20) begin tick(); g++; end
      if (g == 20) chk("tbl_accept", 64'(s_ready), 64'd1);
      tick();
      s_valid = 1'b0;
      lat = 1;
      while (!m_valid && lat < 10) begin tick(); lat++; end
      chk("tbl_latency", 64'(lat), 64'd2);
      chk("tbl_y", 64'(m_y), 64'(vecs[i].y));
      chk("tbl_ovf", 64'(m_ovf), 64'(vecs[i].ovf));
      tick();
    end

    // Backpressure: with the sink stalled only two samples fit in the pipe.
    load_coef(20'd0, 20'd1024);
    got_q.delete();
    m_ready = 1'b0;
    acc = 0;
    x = 20'd1;
    for (int c = 0; c < 4; c++) begin
      s_valid = 1'b1;
      s_x = x;
      a = s_ready;
      tick();
      if (a) begin acc++; x = x + 20'd1; end
    end
    s_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_s_ready", 64'(s_ready), 64'd0);
    chk("bp_head", 64'(m_y), 64'd1);
    y0 = m_y;
    repeat (3) tick();
    chk("bp_stall_valid", 64'(m_valid), 64'd1);
    chk("bp_stall_y", 64'(m_y), 64'(y0));
    m_ready = 1'b1;
    repeat (4) tick();
    chk("bp_out_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk("bp_out0", 64'(got_q[0]), 64'd1);
      chk("bp_out1", 64'(got_q[1]), 64'd2);
    end

    // Coefficient change in the same cycle a sample is accepted.
    load_coef(20'd0, 20'd1024);
    got_q.delete();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_x = 20'd10; tick();
    s_x = 20'd11; tick();
    s_x = 20'd12; coef_ld = 1'b1; b0_in = 20'd5; b1_in = 20'd1024;
    chk("cc_s_ready", 64'(s_ready), 64'd1);
    tick();
    coef_ld = 1'b0;
    s_x = 20'd13; tick();
    s_valid = 1'b0;
    repeat (4) tick();
    chk("cc_out_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      chk("cc_out0", 64'(got_q[0]), 64'd10);
      chk("cc_out1", 64'(got_q[1]), 64'd11);
      chk("cc_out2", 64'(got_q[2]), 64'd12);
      chk("cc_out3", 64'(got_q[3]), 64'd18);
    end

    // Batch: count saturates at N, input closes, coef_ld reopens, reset flushes.
    load_coef(20'd3, 20'd1024);
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 170; i++) begin
      s_x = 20'($urandom_range(0, 1000));
      tick();
    end
    chk("batch_count", 64'(count), 64'd150);
    chk("batch_done", 64'(done), 64'd1);
    chk("batch_s_ready", 64'(s_ready), 64'd0);
    chk("batch_drained", 64'(exp_q.size()), 64'd0);
    repeat (5) tick();
    chk("batch_count_hold", 64'(count), 64'd150);
    load_coef(20'd3, 20'd1024);
    chk("reload_count", 64'(count), 64'd0);
    chk("reload_done", 64'(done), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (3) tick();

    // Randomized traffic, rare reloads and resets; the monitor model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 499) != 0);
      coef_ld = ($urandom_range(0, 399) == 0);
      b0_in   = rand_data();
      b1_in   = rand_data();
      s_valid = ($urandom_range(0, 3) != 0);
      s_x     = rand_data();
      m_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b1; coef_ld = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (5) tick();
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
